// File: rtl/bcrypt_cmp_sharer.sv
// Round-robin sharer of one hash comparator between NUM_REQ bcrypt arbiter groups.
// Optional watchdog in WAIT is compiled in with `define CMP_TIMEOUT_EN; state_dbg exposes the FSM state.
`ifndef HASH_NUM_MSB
`define HASH_NUM_MSB 7
`endif

module bcrypt_cmp_sharer #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [32*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_found,
  output logic [`HASH_NUM_MSB:0]    rsp_hash_num,
  output logic                      rsp_timeout,
  output logic [31:0]               cmp_data,
  output logic                      cmp_start,
  input  logic                      cmp_found,
  input  logic                      cmp_finished,
  input  logic [`HASH_NUM_MSB:0]    cmp_hash_num,
  output logic                      busy,
  output logic                      err_timeout,
  output logic [1:0]                state_dbg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("bcrypt_cmp_sharer: unsupported NUM_REQ/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] pick;
  logic             pick_any;
  logic [PTR_W:0]   idx;

  assign state_dbg = state;

  // Handshake: a group holds req_valid (and stable req_data) until its one-cycle
  // req_ack; the result comes back later as a one-cycle rsp_valid to that group only.
  always_comb begin
    pick     = '0;
    pick_any = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!pick_any && req_valid[idx[PTR_W-1:0]]) begin
        pick     = idx[PTR_W-1:0];
        pick_any = 1'b1;
      end
    end
  end

`ifdef CMP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign rsp_timeout = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      req_ack      <= '0;
      rsp_valid    <= '0;
      rsp_found    <= 1'b0;
      rsp_hash_num <= '0;
      cmp_data     <= '0;
      cmp_start    <= 1'b0;
      busy         <= 1'b0;
`ifdef CMP_TIMEOUT_EN
      tmo_cnt      <= '0;
      rsp_timeout  <= 1'b0;
      err_timeout  <= 1'b0;
`endif
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      cmp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant    <= pick;
            cmp_data <= req_data[32*pick +: 32];
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cmp_start <= 1'b1;
          req_ack   <= ONE << grant;
          rr_ptr    <= (grant == PTR_W'(NUM_REQ-1)) ? '0 : grant + PTR_W'(1);
`ifdef CMP_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
          state     <= WAIT;
        end
        WAIT: begin
          // found takes priority when both comparator flags arrive together
          if (cmp_found) begin
            rsp_valid    <= ONE << grant;
            rsp_found    <= 1'b1;
            rsp_hash_num <= cmp_hash_num;
`ifdef CMP_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
`endif
            state        <= RESP;
          end else if (cmp_finished) begin
            rsp_valid    <= ONE << grant;
            rsp_found    <= 1'b0;
`ifdef CMP_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
`endif
            state        <= RESP;
          end
`ifdef CMP_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES-1)) begin
            rsp_valid   <= ONE << grant;
            rsp_found   <= 1'b0;
            rsp_timeout <= 1'b1;
            err_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcrypt_cmp_sharer.sv
// Directed bench for bcrypt_cmp_sharer: transaction-level timing model checked every
// cycle, plus hand-computed latency/grant/result expectations per scenario.
`ifndef HASH_NUM_MSB
`define HASH_NUM_MSB 7
`endif

module tb_bcrypt_cmp_sharer;
  localparam int N  = 4;
  localparam int T  = 16;
  localparam int HW = `HASH_NUM_MSB + 1;
  localparam int BIG = 1 << 30;
  localparam int K_FIN = 0, K_FOUND = 1, K_BOTH = 2, K_SILENT = 3;
  localparam logic [N-1:0] ONE = N'(1);

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]    req_ack, rsp_valid;
  logic            rsp_found, rsp_timeout, cmp_start, busy, err_timeout;
  logic [HW-1:0]   rsp_hash_num;
  logic [31:0]     cmp_data;
  logic            cmp_found = 1'b0, cmp_finished = 1'b0;
  logic [HW-1:0]   cmp_hash_num = '0;
  logic [1:0]      state_dbg;

  bcrypt_cmp_sharer #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_found(rsp_found), .rsp_hash_num(rsp_hash_num),
    .rsp_timeout(rsp_timeout), .cmp_data(cmp_data), .cmp_start(cmp_start),
    .cmp_found(cmp_found), .cmp_finished(cmp_finished), .cmp_hash_num(cmp_hash_num),
    .busy(busy), .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- comparator stand-in ----------------
  int            cmp_kind = K_FIN;
  int            cmp_delay = 3;
  logic [HW-1:0] cmp_hash = '0;

  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_start === 1'b1) begin
        repeat (cmp_delay) @(posedge CLK);
        #1;
        case (cmp_kind)
          K_FIN:   cmp_finished = 1'b1;
          K_FOUND: begin cmp_found = 1'b1; cmp_hash_num = cmp_hash; end
          K_BOTH:  begin cmp_found = 1'b1; cmp_finished = 1'b1; cmp_hash_num = cmp_hash; end
          default: ;
        endcase
        @(posedge CLK);
        #1;
        cmp_found = 1'b0;
        cmp_finished = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  // Transaction timeline: arbitrate at cycle a, ack+start at a+2, response one cycle
  // after the comparator event, arbitration possible again the cycle after that.
  int            m_rr = 0, m_grant = 0, m_idx = 0;
  int            arb_cyc = -1, start_cyc = -1, rsp_cyc = -1, idle_from = 0, err_from = -1;
  bit            waiting = 0, m_hit = 0;
  logic          e_found = 0, e_tmo = 0;
  logic [HW-1:0] e_hash = '0;
  logic [31:0]   e_data = '0;
  logic [31:0]   exp_q[$];

  always @(negedge CLK) begin
    if (!RESET_N) begin
      check("rst_ctrl", {req_ack, rsp_valid, cmp_start, busy, err_timeout, rsp_found, rsp_timeout}, 64'd0);
      check("rst_data", {rsp_hash_num, cmp_data}, 64'd0);
      m_rr = 0; waiting = 0; arb_cyc = -1; start_cyc = -1; rsp_cyc = -1;
      idle_from = 0; err_from = -1;
      exp_q.delete();
    end else begin
      check("cmp_start", cmp_start, cyc == start_cyc);
      check("req_ack", req_ack, (cyc == start_cyc) ? (ONE << m_grant) : '0);
      check("rsp_valid", rsp_valid, (cyc == rsp_cyc) ? (ONE << m_grant) : '0);
      check("busy", busy, arb_cyc >= 0 && cyc > arb_cyc && cyc < idle_from);
      check("err_timeout", err_timeout, err_from >= 0 && cyc >= err_from);
      if (cyc == start_cyc && exp_q.size() > 0) check("cmp_data", cmp_data, exp_q.pop_front());
      if (cyc == rsp_cyc) begin
        check("rsp_found", rsp_found, e_found);
        check("rsp_timeout", rsp_timeout, e_tmo);
        if (e_found) check("rsp_hash_num", rsp_hash_num, e_hash);
      end
      if (!waiting && cyc >= idle_from && req_valid != '0) begin
        m_hit = 0;
        for (int k = 0; k < N; k++) begin
          m_idx = (m_rr + k) % N;
          if (!m_hit && req_valid[m_idx]) begin m_grant = m_idx; m_hit = 1; end
        end
        e_data = req_data[32*m_grant +: 32];
        exp_q.push_back(e_data);
        m_rr = (m_grant + 1) % N;
        arb_cyc = cyc; start_cyc = cyc + 2; idle_from = BIG; waiting = 1;
      end else if (waiting && cyc >= start_cyc) begin
        if (cmp_found || cmp_finished) begin
          e_found = cmp_found;
          if (cmp_found) e_hash = cmp_hash_num;
          e_tmo = 0;
          waiting = 0; rsp_cyc = cyc + 1; idle_from = cyc + 2;
        end
`ifdef CMP_TIMEOUT_EN
        else if (cyc - start_cyc == T - 1) begin
          e_found = 0; e_tmo = 1; err_from = cyc + 1;
          waiting = 0; rsp_cyc = cyc + 1; idle_from = cyc + 2;
        end
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic wait_ack(input int maxc, output int ac, output logic [N-1:0] av);
    ac = -1; av = '0;
    for (int i = 0; i < maxc && ac < 0; i++) begin
      @(negedge CLK);
      if (req_ack != '0) begin ac = cyc; av = req_ack; end
    end
    check("ack_seen", ac >= 0, 1'b1);
  endtask

  task automatic wait_rsp(input int maxc, output int rc, output logic [N-1:0] rv);
    rc = -1; rv = '0;
    for (int i = 0; i < maxc && rc < 0; i++) begin
      @(negedge CLK);
      if (rsp_valid != '0) begin rc = cyc; rv = rsp_valid; end
    end
    check("rsp_seen", rc >= 0, 1'b1);
  endtask

  task automatic single(input int grp, input logic [31:0] data, input int kind, input int delay,
                        input logic [HW-1:0] hash, input logic exp_found, input bit glitch);
    int c0, ac, rc;
    logic [N-1:0] av, rv;
    cmp_kind = kind; cmp_delay = delay; cmp_hash = hash;
    @(posedge CLK); #1;
    req_valid = ONE << grp;
    req_data[32*grp +: 32] = data;
    c0 = cyc;
    wait_ack(10, ac, av);
    check("ack_latency", ac - c0, 2);
    check("ack_group", av, ONE << grp);
    check("start_with_ack", cmp_start, 1'b1);
    check("start_data", cmp_data, data);
    @(posedge CLK); #1;
    req_valid = '0;
    if (glitch) begin
      // a request that disappears before the next IDLE must never be granted
      @(posedge CLK); #1; req_valid[0] = 1'b1;
      @(posedge CLK); #1; req_valid[0] = 1'b0;
    end
    wait_rsp(60, rc, rv);
    check("rsp_latency", rc - ac, delay + 1);
    check("rsp_group", rv, ONE << grp);
    check("rsp_found_lit", rsp_found, exp_found);
    if (exp_found) check("rsp_hash_lit", rsp_hash_num, hash);
  endtask

  task automatic do_reset();
    @(posedge CLK); #2;
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int ac, rc, n_hit;
    logic [N-1:0] av, rv;
    repeat (2) @(negedge CLK);
    check("reset_state", {req_ack, rsp_valid, cmp_start, busy, err_timeout, cmp_data}, 64'd0);
    @(posedge CLK); #1 RESET_N = 1'b1;

    // single request, comparator finishes 5 cycles after start
    single(1, 32'hDEADBEEF, K_FIN, 5, '0, 1'b0, 1'b0);
    // found with hash 7, with a short-lived request from group 0 during WAIT
    single(2, 32'h12345678, K_FOUND, 6, HW'(7), 1'b1, 1'b1);

    // round-robin with all four groups requesting continuously from reset
    do_reset();
    cmp_kind = K_FIN; cmp_delay = 2;
    @(posedge CLK); #1 req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      wait_ack(20, ac, av);
      check("rr_grant", onehot_idx(av), exp_order[n]);
    end
    @(posedge CLK); #1 req_valid = '0;
    wait_rsp(20, rc, rv);
    check("rr_last_rsp", rv, 4'b0001);

    // found and finished in the same cycle
    single(3, 32'hCAFEF00D, K_BOTH, 4, HW'(5), 1'b1, 1'b0);

    // reset while waiting on the comparator; its late event must be ignored
    cmp_kind = K_FIN; cmp_delay = 6;
    @(posedge CLK); #1;
    req_valid = 4'b0010; req_data[63:32] = 32'h0BADF00D;
    wait_ack(10, ac, av);
    @(posedge CLK); #1 req_valid = '0;
    @(posedge CLK); #2 RESET_N = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_outs", {req_ack, rsp_valid, cmp_start, rsp_found, cmp_data}, 64'd0);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    n_hit = 0;
    repeat (8) begin
      @(negedge CLK);
      if (rsp_valid != '0 || busy) n_hit++;
    end
    check("no_rsp_after_reset", n_hit, 0);

`ifdef CMP_TIMEOUT_EN
    // watchdog: comparator answers only after the timeout has fired
    cmp_kind = K_FIN; cmp_delay = 25;
    @(posedge CLK); #1;
    req_valid = 4'b0100; req_data[95:64] = 32'h55AA55AA;
    wait_ack(10, ac, av);
    @(posedge CLK); #1 req_valid = '0;
    wait_rsp(40, rc, rv);
    check("tmo_latency", rc - ac, T);
    check("tmo_group", rv, 4'b0100);
    check("tmo_flag", rsp_timeout, 1'b1);
    check("tmo_found", rsp_found, 1'b0);
    check("tmo_err", err_timeout, 1'b1);
    n_hit = 0;
    repeat (15) begin
      @(negedge CLK);
      if (rsp_valid != '0) n_hit++;
    end
    check("tmo_late_ignored", n_hit, 0);
    check("tmo_err_sticky", err_timeout, 1'b1);
`endif

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete (checks=%0d failures=%0d)", checks, failures);
    $fatal(1);
  end

endmodule
